// File: rtl/mux_scan_ctrl.sv
// Scan sequencer for a downstream 4:1 single-bit mux: walks the select through the
// enabled channels, holds each for dwell+1 cycles and captures the mux bit per channel.
module mux_scan_ctrl #(
    parameter int unsigned DWELL_W = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [3:0]         mask,
    input  logic [DWELL_W-1:0] dwell,
    input  logic               mux_out,
    output logic [1:0]         s,
    output logic               busy,
    output logic               done,
    output logic [3:0]         sample
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DWELL = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [1:0]         s_q, s_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [3:0]         sample_q, sample_d;
    logic [3:0]         mask_q, mask_d;
    logic [DWELL_W-1:0] dwell_q, dwell_d;
    logic [DWELL_W-1:0] cnt_q, cnt_d;
    logic [3:0]         remaining;

    // Index of the lowest set bit; callers guarantee m != 0.
    function automatic logic [1:0] low_idx(input logic [3:0] m);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (m[i]) idx = 2'(i);
        end
        return idx;
    endfunction

    // Enabled channels strictly above the current one, so s never wraps back.
    assign remaining = mask_q & 4'(4'b1110 << s_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            s_q      <= 2'd0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            sample_q <= 4'd0;
            mask_q   <= 4'd0;
            dwell_q  <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            s_q      <= s_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            sample_q <= sample_d;
            mask_q   <= mask_d;
            dwell_q  <= dwell_d;
            cnt_q    <= cnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        s_d      = s_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        sample_d = sample_q;
        mask_d   = mask_q;
        dwell_d  = dwell_q;
        cnt_d    = cnt_q;

        unique case (state_q)
            IDLE: begin
                s_d    = 2'd0;
                busy_d = 1'b0;
                if (start) begin
                    sample_d = 4'd0;
                    if (mask != 4'd0) begin
                        state_d = DWELL;
                        mask_d  = mask;
                        dwell_d = dwell;
                        cnt_d   = dwell;
                        s_d     = low_idx(mask);
                        busy_d  = 1'b1;
                    end else begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end
                end
            end
            DWELL: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - DWELL_W'(1);
                end else begin
                    sample_d[s_q] = mux_out;
                    if (remaining != 4'd0) begin
                        s_d   = low_idx(remaining);
                        cnt_d = dwell_q;
                    end else begin
                        state_d = DONE;
                        s_d     = 2'd0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                s_d     = 2'd0;
                busy_d  = 1'b0;
            end
        endcase
    end

    assign s      = s_q;
    assign busy   = busy_q;
    assign done   = done_q;
    assign sample = sample_q;

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Bench for mux_scan_ctrl: a cycle-indexed timeline model is compared against the DUT
// on every falling edge, and each directed scan is pinned by literal done cycle and sample.
module tb_mux_scan_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [3:0] mask = 4'd0;
    logic [3:0] dwell = 4'd0;
    logic [3:0] in_v = 4'd0;
    logic       mux_out;
    logic [1:0] s;
    logic       busy;
    logic       done;
    logic [3:0] sample;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    assign mux_out = in_v[s];

    mux_scan_ctrl #(.DWELL_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .mask(mask), .dwell(dwell),
        .mux_out(mux_out), .s(s), .busy(busy), .done(done), .sample(sample)
    );

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // slot-th enabled channel in ascending order
    function automatic int chan_of(input logic [3:0] m, input int slot);
        int k;
        k = 0;
        for (int i = 0; i < 4; i++) begin
            if (m[i]) begin
                if (k == slot) return i;
                k++;
            end
        end
        return 0;
    endfunction

    // Model: a scan accepted at edge 0 occupies cycles 1..n*(d+1), done in the next one.
    logic       m_active;
    int         m_t;
    int         m_n;
    int         m_d;
    logic [3:0] m_mask;
    logic [3:0] m_sample;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_active <= 1'b0;
            m_t      <= 0;
            m_n      <= 0;
            m_d      <= 0;
            m_mask   <= 4'd0;
            m_sample <= 4'd0;
        end else if (m_active) begin
            if (m_t >= 1 && m_t <= m_n * (m_d + 1) && ((m_t - 1) % (m_d + 1)) == m_d)
                m_sample[chan_of(m_mask, (m_t - 1) / (m_d + 1))] <=
                    in_v[chan_of(m_mask, (m_t - 1) / (m_d + 1))];
            if (m_t == m_n * (m_d + 1) + 1) m_active <= 1'b0;
            m_t <= m_t + 1;
        end else if (start) begin
            m_active <= 1'b1;
            m_t      <= 1;
            m_n      <= $countones(mask);
            m_d      <= int'(dwell);
            m_mask   <= mask;
            m_sample <= 4'd0;
        end
    end

    always @(negedge clk) begin
        int es, eb, ed;
        es = 0; eb = 0; ed = 0;
        if (m_active) begin
            if (m_t <= m_n * (m_d + 1)) begin
                es = chan_of(m_mask, (m_t - 1) / (m_d + 1));
                eb = 1;
            end else begin
                ed = 1;
            end
        end
        chk("s", int'(s), es);
        chk("busy", int'(busy), eb);
        chk("done", int'(done), ed);
        chk("sample", int'(sample), int'(m_sample));
    end

    // One scan: start in cycle -1 so edge 0 accepts it; optional re-pulse and in[3] toggling.
    task automatic run_scan(input string nm, input logic [3:0] mk, input logic [3:0] dw,
                            input logic [3:0] iv, input bit tog, input int repulse,
                            input int exp_done, input logic [3:0] exp_smp);
        int k, done_at, done_cnt;
        k = 0; done_at = -1; done_cnt = 0;
        @(posedge clk); #1;
        start = 1'b1; mask = mk; dwell = dw; in_v = iv;
        while (k < 300 && done_at < 0) begin
            @(posedge clk); #1;
            k++;
            start = 1'b0;
            if (k == 2) begin
                mask = ~mk;
                dwell = dw ^ 4'd5;
            end
            if (k == repulse) begin
                start = 1'b1;
                mask = 4'b0001;
                dwell = 4'd0;
            end
            if (tog) in_v[3] = (k % 2 == 0);
            @(negedge clk);
            if (done) begin
                done_at = k;
                done_cnt++;
            end
        end
        chk({nm, " done cycle"}, done_at, exp_done);
        chk({nm, " sample"}, int'(sample), int'(exp_smp));
        chk({nm, " model sample"}, int'(m_sample), int'(exp_smp));
        repeat (2) @(negedge clk);
        chk({nm, " sample hold"}, int'(sample), int'(exp_smp));
    endtask

    initial begin
        int done_seen;
        #1;
        chk("reset s", int'(s), 0);
        chk("reset busy", int'(busy), 0);
        chk("reset done", int'(done), 0);
        chk("reset sample", int'(sample), 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        run_scan("all d0",    4'b1111, 4'd0,  4'b1010, 1'b0, -1, 5,  4'b1010);
        run_scan("m0101 d2",  4'b0101, 4'd2,  4'b1111, 1'b0, -1, 7,  4'b0101);
        run_scan("mask0",     4'b0000, 4'd3,  4'b1111, 1'b0, -1, 1,  4'b0000);
        run_scan("toggle",    4'b1000, 4'd3,  4'b0000, 1'b1, -1, 5,  4'b1000);
        run_scan("repulse",   4'b1111, 4'd1,  4'b0110, 1'b0, 3,  9,  4'b0110);
        run_scan("dwell max", 4'b0010, 4'd15, 4'b0010, 1'b0, -1, 17, 4'b0010);

        // Reset mid-scan: ch0 already captured (1) before reset lands in cycle 6.
        @(posedge clk); #1;
        start = 1'b1; mask = 4'b1111; dwell = 4'd4; in_v = 4'b0101;
        for (int k = 1; k <= 6; k++) begin
            @(posedge clk); #1;
            start = 1'b0;
        end
        chk("pre-reset sample", int'(sample), 1);
        rst_n = 1'b0;
        #1;
        chk("mid reset s", int'(s), 0);
        chk("mid reset busy", int'(busy), 0);
        chk("mid reset sample", int'(sample), 0);
        done_seen = 0;
        repeat (3) begin
            @(negedge clk);
            if (done) done_seen++;
        end
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (2) begin
            @(negedge clk);
            if (done) done_seen++;
        end
        chk("no done on reset", done_seen, 0);
        run_scan("after reset", 4'b1111, 4'd4, 4'b1100, 1'b0, -1, 21, 4'b1100);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
